// File: rtl/sram_arb_pkg.sv
// Shared owner tags and access-size encodings for the sram-like arbiter.
package sram_arb_pkg;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/sram_arb_order_fifo.sv
// In-order owner queue: one bit per accepted transaction, oldest at the head.
// Push and pop together when full is legal and leaves the count unchanged.
module sram_arb_order_fifo
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic                     i_din,
  input  logic                     i_pop,
  output logic                     o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

  logic          r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CNT_FULL);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-requester (inst/data) arbiter onto one sram-like master port with in-order response routing.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority.
module sram_like_arbiter
  import sram_arb_pkg::*;
#(
  parameter int MAX_OUTST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic        arb_err
);

  logic                         r_lock;
  logic                         r_lock_own;
  logic                         r_arb_err;
  logic                         w_gnt_valid;
  logic                         w_gnt_own;
  logic                         w_pref_own;
  logic                         w_push;
  logic                         w_head;
  logic                         w_full;
  logic                         w_empty;
  logic [$clog2(MAX_OUTST):0]   w_count;

`ifdef SRAM_ARB_RR_EN
  logic r_rr_own;

  // Hand priority to the other requester after every accepted address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_own <= OWN_DATA;
    end else if (w_push) begin
      r_rr_own <= ~w_gnt_own;
    end else begin
      r_rr_own <= r_rr_own;
    end
  end

  assign w_pref_own = r_rr_own;
`else
  assign w_pref_own = OWN_DATA;
`endif

  // Grant: a held lock wins while its owner still requests; full queue blocks everything.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_own   = OWN_DATA;
    if (reset || w_full) begin
      w_gnt_valid = 1'b0;
    end else if (r_lock && (r_lock_own == OWN_DATA) && data_req) begin
      w_gnt_valid = 1'b1;
      w_gnt_own   = OWN_DATA;
    end else if (r_lock && (r_lock_own == OWN_INST) && inst_req) begin
      w_gnt_valid = 1'b1;
      w_gnt_own   = OWN_INST;
    end else if (data_req && inst_req) begin
      w_gnt_valid = 1'b1;
      w_gnt_own   = w_pref_own;
    end else if (data_req) begin
      w_gnt_valid = 1'b1;
      w_gnt_own   = OWN_DATA;
    end else if (inst_req) begin
      w_gnt_valid = 1'b1;
      w_gnt_own   = OWN_INST;
    end else begin
      w_gnt_valid = 1'b0;
    end
  end

  // Request mux; attributes are zero whenever nothing is granted.
  always_comb begin
    m_req   = w_gnt_valid;
    m_wr    = 1'b0;
    m_size  = 2'd0;
    m_wstrb = 4'd0;
    m_addr  = 32'd0;
    m_wdata = 32'd0;
    if (w_gnt_valid && (w_gnt_own == OWN_DATA)) begin
      m_wr    = data_wr;
      m_size  = data_size;
      m_wstrb = data_wstrb;
      m_addr  = data_addr;
      m_wdata = data_wdata;
    end else if (w_gnt_valid) begin
      m_wr    = inst_wr;
      m_size  = inst_size;
      m_wstrb = inst_wstrb;
      m_addr  = inst_addr;
      m_wdata = inst_wdata;
    end else begin
      m_req   = 1'b0;
    end
  end

  assign w_push       = m_req && m_addr_ok;
  assign inst_addr_ok = w_push && (w_gnt_own == OWN_INST);
  assign data_addr_ok = w_push && (w_gnt_own == OWN_DATA);
  assign inst_data_ok = m_data_ok && !w_empty && (w_head == OWN_INST);
  assign data_data_ok = m_data_ok && !w_empty && (w_head == OWN_DATA);
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;
  assign arb_err      = r_arb_err;

  // Lock holds the grant across a stalled address phase; a dropped request releases it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock     <= 1'b0;
      r_lock_own <= OWN_INST;
    end else if (m_req && !m_addr_ok) begin
      r_lock     <= 1'b1;
      r_lock_own <= w_gnt_own;
    end else begin
      r_lock     <= 1'b0;
      r_lock_own <= r_lock_own;
    end
  end

  // Sticky flag for a response that has no outstanding owner.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_arb_err <= 1'b0;
    end else if (m_data_ok && w_empty) begin
      r_arb_err <= 1'b1;
    end else begin
      r_arb_err <= r_arb_err;
    end
  end

  sram_arb_order_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_order_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_push  (w_push),
    .i_din   (w_gnt_own),
    .i_pop   (m_data_ok),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter (default fixed-priority build, MAX_OUTST = 4).
module tb_sram_like_arbiter;
  import sram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        m_req, m_wr, m_addr_ok, m_data_ok;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        arb_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.MAX_OUTST(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .arb_err(arb_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = SZ_WORD; inst_wstrb = 4'h0;
    inst_addr = 32'hBFC0_0000; inst_wdata = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = SZ_WORD; data_wstrb = 4'h0;
    data_addr = 32'h0000_1000; data_wdata = 32'h0;
    m_addr_ok = 1'b1; m_data_ok = 1'b0; m_rdata = 32'h0;

    // Reset: m_req forced low even with a request pending
    settle();
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    nxt();
    reset = 1'b0; inst_req = 1'b0;
    settle();
    chk("rst_arb_err", 32'(arb_err), 32'd0);
    chk("idle_m_req", 32'(m_req), 32'd0);
    chk("idle_m_addr", m_addr, 32'd0);

    // Priority: data first, then inst; responses routed in order
    nxt();
    inst_req = 1'b1; data_req = 1'b1;
    settle();
    chk("prio_m_addr0", m_addr, 32'h0000_1000);
    chk("prio_data_aok", 32'(data_addr_ok), 32'd1);
    chk("prio_inst_aok0", 32'(inst_addr_ok), 32'd0);
    nxt();
    data_req = 1'b0;
    settle();
    chk("prio_m_addr1", m_addr, 32'hBFC0_0000);
    chk("prio_inst_aok1", 32'(inst_addr_ok), 32'd1);
    nxt();
    inst_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'hAAAA_0001;
    settle();
    chk("prio_data_dok", 32'(data_data_ok), 32'd1);
    chk("prio_inst_dok0", 32'(inst_data_ok), 32'd0);
    chk("prio_data_rdata", data_rdata, 32'hAAAA_0001);
    nxt();
    m_rdata = 32'hBBBB_0002;
    settle();
    chk("prio_inst_dok1", 32'(inst_data_ok), 32'd1);
    chk("prio_data_dok1", 32'(data_data_ok), 32'd0);
    chk("prio_inst_rdata", inst_rdata, 32'hBBBB_0002);

    // Lock: stalled inst keeps the port although data requests
    nxt();
    m_data_ok = 1'b0; inst_req = 1'b1;
    settle();
    chk("lock_c0_addr", m_addr, 32'hBFC0_0000);
    chk("lock_c0_aok", 32'(inst_addr_ok), 32'd0);
    nxt();
    data_req = 1'b1; data_wr = 1'b1; data_wdata = 32'h1234_5678; data_wstrb = 4'hF;
    settle();
    chk("lock_c1_addr", m_addr, 32'hBFC0_0000);
    chk("lock_c1_wr", 32'(m_wr), 32'd0);
    nxt();
    settle();
    chk("lock_c2_addr", m_addr, 32'hBFC0_0000);
    nxt();
    m_addr_ok = 1'b1;
    settle();
    chk("lock_c3_addr", m_addr, 32'hBFC0_0000);
    chk("lock_c3_inst_aok", 32'(inst_addr_ok), 32'd1);
    chk("lock_c3_data_aok", 32'(data_addr_ok), 32'd0);
    nxt();
    inst_req = 1'b0;
    settle();
    chk("lock_c4_addr", m_addr, 32'h0000_1000);
    chk("lock_c4_wr", 32'(m_wr), 32'd1);
    chk("lock_c4_wdata", m_wdata, 32'h1234_5678);
    chk("lock_c4_wstrb", 32'(m_wstrb), 32'hF);
    chk("lock_c4_size", 32'(m_size), 32'(SZ_WORD));
    chk("lock_c4_data_aok", 32'(data_addr_ok), 32'd1);
    nxt();
    data_req = 1'b0; data_wr = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
    settle();
    chk("lock_ret_inst", 32'(inst_data_ok), 32'd1);
    nxt();
    settle();
    chk("lock_ret_data", 32'(data_data_ok), 32'd1);

    // Full: four inst fetches fill the queue, fifth is held off
    nxt();
    m_data_ok = 1'b0; inst_req = 1'b1; m_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("full_aok%0d", i), 32'(inst_addr_ok), 32'd1);
      nxt();
    end
    settle();
    chk("full_m_req", 32'(m_req), 32'd0);
    chk("full_aok4", 32'(inst_addr_ok), 32'd0);
    nxt();
    m_data_ok = 1'b1;
    settle();
    chk("full_pop_dok", 32'(inst_data_ok), 32'd1);
    chk("full_pop_m_req", 32'(m_req), 32'd0);
    nxt();
    m_data_ok = 1'b0;
    settle();
    chk("full_after_m_req", 32'(m_req), 32'd1);
    chk("full_after_aok", 32'(inst_addr_ok), 32'd1);
    nxt();
    inst_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("full_drain%0d", i), 32'(inst_data_ok), 32'd1);
      nxt();
    end
    m_data_ok = 1'b0;

    // Push/pop each cycle with alternating owners across the pointer wrap
    inst_req = 1'b1; m_addr_ok = 1'b1;
    settle();
    chk("pp_prime_aok", 32'(inst_addr_ok), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      nxt();
      inst_req = (k % 2 == 0); data_req = (k % 2 == 1); m_data_ok = 1'b1;
      settle();
      chk($sformatf("pp%0d_aok", k), 32'(k % 2 == 1 ? data_addr_ok : inst_addr_ok), 32'd1);
      chk($sformatf("pp%0d_inst_dok", k), 32'(inst_data_ok), 32'((k - 1) % 2 == 0));
      chk($sformatf("pp%0d_data_dok", k), 32'(data_data_ok), 32'((k - 1) % 2 == 1));
    end
    nxt();
    inst_req = 1'b0; data_req = 1'b0; m_addr_ok = 1'b0;
    settle();
    chk("pp_last_inst_dok", 32'(inst_data_ok), 32'd1);
    chk("pp_last_err", 32'(arb_err), 32'd0);

    // Error: response with an empty queue
    nxt();
    settle();
    chk("err_inst_dok", 32'(inst_data_ok), 32'd0);
    chk("err_data_dok", 32'(data_data_ok), 32'd0);
    nxt();
    m_data_ok = 1'b0;
    settle();
    chk("err_set", 32'(arb_err), 32'd1);
    nxt();
    nxt();
    settle();
    chk("err_sticky", 32'(arb_err), 32'd1);

    // Reset mid-flight: two data transactions discarded
    nxt();
    data_req = 1'b1; m_addr_ok = 1'b1;
    nxt();
    nxt();
    data_req = 1'b0; inst_req = 1'b1; reset = 1'b1;
    settle();
    chk("mid_rst_m_req", 32'(m_req), 32'd0);
    nxt();
    reset = 1'b0;
    settle();
    chk("mid_err_clr", 32'(arb_err), 32'd0);
    chk("mid_inst_aok", 32'(inst_addr_ok), 32'd1);
    nxt();
    inst_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
    settle();
    chk("mid_inst_dok", 32'(inst_data_ok), 32'd1);
    chk("mid_data_dok", 32'(data_data_ok), 32'd0);
    nxt();
    settle();
    chk("mid_empty_dok", 32'(data_data_ok | inst_data_ok), 32'd0);
    nxt();
    m_data_ok = 1'b0;
    settle();
    chk("mid_empty_err", 32'(arb_err), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
